// File: rtl/gfx_float_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_float_to_int
//  Description : Three-stage pipelined IEEE-754 binary32 to signed int32
//                converter. It rounds to nearest-even (or truncates when
//                ROUND_RNE=0), saturates on overflow, flushes denormals
//                to zero and maps NaN to 0. The whole pipeline advances
//                on a single valid/ready stall.
//                Optional macro GFX_FLOAT_TO_INT_FLAGS_EN adds the
//                out_flags = {invalid, inexact} output.
//  Revision    : 1.0  initial release
// ============================================================================
module gfx_float_to_int #(
  parameter int ROUND_RNE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
  output logic [1:0]  out_flags,
`endif
  output logic [31:0] out_int
);

  // Result class carried from the shift stage to the round/saturate stage
  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_NAN  = 2'd1,
    CLS_SAT  = 2'd2,
    CLS_MIN  = 2'd3
  } cls_e;

  logic              w_adv;

  // S0 classify registers
  logic              r0_valid;
  logic              r0_sign;
  logic signed [8:0] r0_exp;
  logic              r0_exp_max;
  logic              r0_exp_min;
  logic              r0_mant_zero;
  logic [23:0]       r0_mant;

  // S1 shift registers
  logic              r1_valid;
  logic              r1_sign;
  cls_e              r1_class;
  logic [31:0]       r1_mag;
  logic              r1_guard;
  logic              r1_sticky;

  // S1 combinational
  cls_e              w1_class;
  logic [31:0]       w1_mag;
  logic              w1_guard;
  logic              w1_sticky;
  logic [2:0]        w1_shl_amt;
  logic [4:0]        w1_shr_amt;
  logic [31:0]       w1_shl;
  logic [47:0]       w1_shr;

  // S2 combinational
  logic              w2_inc;
  logic [31:0]       w2_rnd;
  logic [31:0]       w2_signed;
  logic [31:0]       w2_int;

  // The whole pipeline moves together whenever the output slot is free
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // For 23 <= e <= 30, e - 23 equals (e[2:0] + 1) modulo 8
  assign w1_shl_amt = r0_exp[2:0] + 3'd1;
  // For -1 <= e <= 22 the right shift 23 - e lies in 1..24 and fits 5 bits
  assign w1_shr_amt = 5'd23 - r0_exp[4:0];

  assign w1_shl = {8'd0, r0_mant} << w1_shl_amt;
  // Mantissa parked above 24 zero bits: after the shift the integer part
  // sits in [47:24], the guard bit in [23] and the sticky bits below it
  assign w1_shr = {r0_mant, 24'd0} >> w1_shr_amt;

  // S1: pick the magnitude, guard and sticky bits from the exponent range
  always_comb begin
    w1_class  = CLS_NORM;
    w1_mag    = 32'd0;
    w1_guard  = 1'b0;
    w1_sticky = 1'b0;
    if (r0_exp_max) begin
      w1_class = r0_mant_zero ? CLS_SAT : CLS_NAN;
    end else if (r0_exp_min) begin
      w1_sticky = ~r0_mant_zero;
    end else if (r0_exp >= 9'sd31) begin
      // -2^31 is the only out-of-range magnitude that is still representable
      if (r0_sign && (r0_exp == 9'sd31) && r0_mant_zero) begin
        w1_class = CLS_MIN;
      end else begin
        w1_class = CLS_SAT;
      end
    end else if (r0_exp >= 9'sd23) begin
      w1_mag = w1_shl;
    end else if (r0_exp >= -9'sd1) begin
      w1_mag    = {8'd0, w1_shr[47:24]};
      w1_guard  = w1_shr[23];
      w1_sticky = |w1_shr[22:0];
    end else begin
      // Below 0.5: the hidden bit always makes the remainder nonzero
      w1_sticky = 1'b1;
    end
  end

  // Increment only when rounding is enabled and the remainder is above
  // one half, or exactly one half with an odd integer part
  assign w2_inc    = (ROUND_RNE != 0) && r1_guard && (r1_sticky || r1_mag[0]);
  assign w2_rnd    = r1_mag + {31'd0, w2_inc};
  assign w2_signed = r1_sign ? (~w2_rnd + 32'd1) : w2_rnd;

  // S2: apply class overrides on top of the rounded, signed value
  always_comb begin
    w2_int = w2_signed;
    case (r1_class)
      CLS_NAN: w2_int = 32'h0000_0000;
      CLS_SAT: w2_int = r1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
      CLS_MIN: w2_int = 32'h8000_0000;
      default: w2_int = w2_signed;
    endcase
  end

`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
  logic [1:0] w2_flags;
  logic       w2_invalid;

  assign w2_invalid = (r1_class == CLS_NAN) || (r1_class == CLS_SAT);

  // Flags: invalid for NaN or saturation, inexact for any discarded fraction
  always_comb begin
    w2_flags = {w2_invalid, (r1_guard | r1_sticky) & ~w2_invalid};
  end
`endif

  // Stage valids and the output register; out_int only updates on real data
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid  <= 1'b0;
      r1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_int   <= 32'd0;
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
      out_flags <= 2'b00;
`endif
    end else if (w_adv) begin
      r0_valid  <= in_valid & in_ready;
      r1_valid  <= r0_valid;
      out_valid <= r1_valid;
      if (r1_valid) begin
        out_int <= w2_int;
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
        out_flags <= w2_flags;
`endif
      end
    end
  end

  // Stage data registers; contents of invalid stages are don't-care
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r0_sign      <= in_float[31];
      r0_exp       <= $signed({1'b0, in_float[30:23]}) - 9'sd127;
      r0_exp_max   <= &in_float[30:23];
      r0_exp_min   <= ~|in_float[30:23];
      r0_mant_zero <= ~|in_float[22:0];
      r0_mant      <= {1'b1, in_float[22:0]};

      r1_sign      <= r0_sign;
      r1_class     <= w1_class;
      r1_mag       <= w1_mag;
      r1_guard     <= w1_guard;
      r1_sticky    <= w1_sticky;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gfx_float_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gfx_float_to_int
//  Description : Scoreboard bench for gfx_float_to_int. Two instances
//                (round-to-nearest-even and truncate) share one stimulus
//                stream; expected results come from an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gfx_float_to_int;

  typedef struct {
    logic [31:0] val;
    logic [1:0]  flg;
    logic [31:0] src;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_float = 32'd0;
  logic        out_ready = 1'b1;
  logic        in_ready_rne, in_ready_trn;
  logic        out_valid_rne, out_valid_trn;
  logic [31:0] out_int_rne, out_int_trn;
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
  logic [1:0]  flags_rne, flags_trn;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   tag_lat = 1'b0;
  bit   rnd_done = 1'b0;
  exp_t q_rne[$];
  exp_t q_trn[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gfx_float_to_int #(.ROUND_RNE(1)) dut_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_rne),
    .in_float(in_float), .out_valid(out_valid_rne), .out_ready(out_ready),
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
    .out_flags(flags_rne),
`endif
    .out_int(out_int_rne)
  );

  gfx_float_to_int #(.ROUND_RNE(0)) dut_trn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_trn),
    .in_float(in_float), .out_valid(out_valid_trn), .out_ready(out_ready),
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
    .out_flags(flags_trn),
`endif
    .out_int(out_int_trn)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: value = m * 2^(e-23); integer quotient/remainder rounding
  function automatic exp_t model(input logic [31:0] f, input bit rne);
    exp_t   r;
    int     ex, e, k;
    longint m, q, rem, half, mag, v;
    bit     inexact, up;
    r.src = f; r.acc = 0; r.lat = 1'b0;
    ex = int'(f[30:23]);
    m  = longint'({1'b1, f[22:0]});
    inexact = 1'b0;
    if (ex == 255) begin
      r.val = (f[22:0] != 0) ? 32'h0 : (f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      r.flg = 2'b10;
    end else if (ex == 0) begin
      r.val = 32'h0;
      r.flg = {1'b0, f[22:0] != 0};
    end else begin
      e = ex - 127;
      if (e > 31) begin
        mag = 64'h1_0000_0000;
      end else if (e >= 23) begin
        mag = m << (e - 23);
      end else begin
        k = 23 - e;
        if (k >= 40) begin
          q = 0; up = 1'b0; inexact = 1'b1;
        end else begin
          q    = m >> k;
          rem  = m - (q << k);
          half = longint'(1) << (k - 1);
          inexact = (rem != 0);
          up = rne && ((rem > half) || (rem == half && q[0]));
        end
        mag = q + longint'(up);
      end
      v = f[31] ? -mag : mag;
      if (v > 64'sd2147483647) begin
        r.val = 32'h7FFF_FFFF; r.flg = 2'b10;
      end else if (v < -64'sd2147483648) begin
        r.val = 32'h8000_0000; r.flg = 2'b10;
      end else begin
        r.val = v[31:0]; r.flg = {1'b0, inexact};
      end
    end
    return r;
  endfunction

  // Scoreboard: record accepted operands, then pop and compare every output
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_rne.delete();
      q_trn.delete();
    end else begin
      if (in_valid && in_ready_rne) begin
        e = model(in_float, 1'b1); e.acc = cyc; e.lat = tag_lat; q_rne.push_back(e);
        e = model(in_float, 1'b0); e.acc = cyc; e.lat = tag_lat; q_trn.push_back(e);
      end
      if (out_valid_rne && out_ready) begin
        if (q_rne.size() == 0) begin
          chk("rne_unexpected_output", out_int_rne, 32'hxxxx_xxxx);
        end else begin
          e = q_rne.pop_front();
          chk($sformatf("rne_int src=%h", e.src), out_int_rne, e.val);
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
          chk($sformatf("rne_flags src=%h", e.src), {30'd0, flags_rne}, {30'd0, e.flg});
`endif
          if (e.lat) chk($sformatf("rne_latency src=%h", e.src), cyc, e.acc + 3);
        end
      end
      if (out_valid_trn && out_ready) begin
        if (q_trn.size() == 0) begin
          chk("trn_unexpected_output", out_int_trn, 32'hxxxx_xxxx);
        end else begin
          e = q_trn.pop_front();
          chk($sformatf("trn_int src=%h", e.src), out_int_trn, e.val);
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
          chk($sformatf("trn_flags src=%h", e.src), {30'd0, flags_trn}, {30'd0, e.flg});
`endif
          if (e.lat) chk($sformatf("trn_latency src=%h", e.src), cyc, e.acc + 3);
        end
      end
    end
  end

  // Present one operand and hold it until accepted (bounded wait)
  task automatic send(input logic [31:0] f, input bit lat);
    in_float = f;
    in_valid = 1'b1;
    tag_lat  = lat;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready_rne) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] sp [8];
    logic [7:0]  ex;
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
           32'h7FC0_0000, 32'hCF00_0000, 32'h4F00_0000, 32'h0000_0001};
    case ($urandom % 4)
      0: return $urandom;
      1: begin ex = 8'($urandom_range(120, 160)); return {1'($urandom), ex, 23'($urandom)}; end
      2: begin ex = 8'($urandom_range(125, 150)); return {1'($urandom), ex, 23'($urandom) & 23'h7F_FF00}; end
      default: return sp[$urandom % 8];
    endcase
  endfunction

  logic [31:0] dvec [17] = '{
    32'h4020_0000, 32'h4060_0000, 32'hC020_0000, 32'h3F00_0000, 32'h3F40_0000,
    32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000,
    32'h0000_0001, 32'h4EFF_FFFF, 32'h4B00_0001, 32'h3F7F_FFFF, 32'hC060_0000,
    32'hCF00_0001, 32'h3FC0_0000};
  logic [31:0] ones [8] = '{
    32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
    32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  initial begin
    logic [31:0] held;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready_rne}, 32'd1);
    chk("reset_out_valid_rne", {31'd0, out_valid_rne}, 32'd0);
    chk("reset_out_valid_trn", {31'd0, out_valid_trn}, 32'd0);
    chk("reset_out_int", out_int_rne, 32'd0);
`ifdef GFX_FLOAT_TO_INT_FLAGS_EN
    chk("reset_flags", {30'd0, flags_rne}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, back-to-back with a free-running consumer
    for (int i = 0; i < 17; i++) send(dvec[i], 1'b1);
    repeat (6) @(posedge clk); #1;

    // Backpressure: 8 operands, consumer stalls for cycles 4..9
    fork
      begin
        for (int i = 0; i < 8; i++) send(ones[i], 1'b0);
      end
      begin
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_int_rne;
        for (int j = 0; j < 6; j++) begin
          if (j > 0) @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready_rne}, 32'd0);
          chk("stall_out_int_stable", out_int_rne, held);
          chk("stall_out_valid", {31'd0, out_valid_rne}, 32'd1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    // Reset with three operands in flight
    out_ready = 1'b0;
    send(32'h4080_0000, 1'b0);
    send(32'h40A0_0000, 1'b0);
    send(32'h40C0_0000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid_rne", {31'd0, out_valid_rne}, 32'd0);
    chk("post_reset_out_valid_trn", {31'd0, out_valid_trn}, 32'd0);
    @(posedge clk); #1;
    send(32'h4120_0000, 1'b1);
    repeat (5) @(posedge clk); #1;

    // Randomised traffic with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rand_float(), 1'b0);
          if ($urandom % 3 == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
        end
        out_ready = 1'b1;
      end
    join

    // Drain and confirm nothing was lost
    for (int t = 0; t < 100 && (q_rne.size() != 0 || q_trn.size() != 0); t++) @(posedge clk);
    @(negedge clk);
    chk("drain_rne_queue_empty", q_rne.size(), 32'd0);
    chk("drain_trn_queue_empty", q_trn.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gfx_float_to_int.md
Name: gfx_float_to_int

Overview:
- Pipelined float-to-signed-int32 converter: the decode direction of the shader fpint encode path.
- Takes an IEEE-754 binary32 `gfx::float` and returns a `gfx::word` two's-complement integer.
- Rounding is round-to-nearest-even, with saturation on overflow.
- One instance per shader lane; sits beside the fpint pipeline and uses the same valid/ready stall convention at both ends.

Parameters:
- ROUND_RNE, 1, 1 = round-to-nearest-even; 0 = truncate toward zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter can accept this cycle
- in_float  in  32  operand, type `gfx::float`
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_int  out  32  result, type `gfx::word`, signed

Behaviour:
Interface and reset
- One clock; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_int=0, all internal stage valids=0.
- Reset asserted mid-operation discards every in-flight operand; no output appears for them.

Pipeline and handshake
- 3 register stages: S0 classify, S1 shift, S2 round/saturate.
- Global advance: adv = ~out_valid | out_ready; in_ready = adv.
- On adv, every stage shifts forward, and S0 valid loads in_valid & in_ready.
- When adv=0, all stages hold, and out_valid/out_int stay stable until accepted.
- Latency is exactly 3 cycles from acceptance to out_valid when no stall occurs.
- Throughput is 1/cycle under continuous out_ready=1.
- Bubbles propagate as invalid stages. Data in invalid stages is don't-care, but out_int holds its last value when out_valid=0.

S0 (classify)
- Register the sign.
- Compute unbiased e = exp - 127 as a 9-bit signed value.
- Register the float_class flags (exp_max, exp_min, mant_zero).
- Register full mantissa m = {1, mant}, 24 bits.

S1 (shift)
- exp_max & ~mant_zero (NaN): result class NAN.
- exp_max & mant_zero (Inf): class SAT.
- exp_min (zero or denormal): magnitude 0, guard=0, sticky=~mant_zero. Denormals are flushed to zero.
- e >= 31: class SAT.
  - Exception: sign=1, e=31, mant_zero gives magnitude 2^31 exactly, class EXACT_MIN.
- 23 <= e <= 30: magnitude = m << (e-23), guard=0, sticky=0.
- 0 <= e < 23:
  - magnitude = m >> (23-e)
  - guard = bit (22-e) of m
  - sticky = OR of m bits below guard
- e < 0:
  - magnitude 0
  - e = -1: guard = 1, sticky = |m[22:0]
  - e <= -2: guard = 0, sticky = 1

S2 (round and saturate)
- With ROUND_RNE=1: increment when guard & (sticky | magnitude[0]).
- Rounding cannot overflow, because rounding only occurs for e < 23.
- Apply negation if sign=1.
- Class overrides:
  - NAN gives 0.
  - SAT gives 32'h7FFFFFFF (sign=0) or 32'h80000000 (sign=1).
  - EXACT_MIN gives 32'h80000000.
- -0.0 gives 0.

Optional Feature:
Macro GFX_FLOAT_TO_INT_FLAGS_EN.
- Defined:
  - Adds output port out_flags (2 bits, {invalid, inexact}), valid with out_valid and reset 0.
  - invalid = NaN or SAT class.
  - inexact = (guard | sticky) and not invalid.
- Undefined:
  - Port absent.
  - Flag logic and flag pipeline registers are not synthesized.
  - Data path is unchanged.

Test Plan:
- RNE ties (ROUND_RNE=1):
  - 32'h40200000 (2.5) -> 2
  - 32'h40600000 (3.5) -> 4
  - 32'hC0200000 (-2.5) -> 32'hFFFFFFFE
  - 32'h3F000000 (0.5) -> 0
  - 32'h3F400000 (0.75) -> 1
  - each 3 cycles after acceptance; inexact=1.
- Saturation and specials:
  - 32'h4F000000 -> 32'h7FFFFFFF, invalid=1
  - 32'hCF000000 -> 32'h80000000, invalid=0
  - 32'hFF800000 -> 32'h80000000, invalid=1
  - 32'h7FC00000 -> 0, invalid=1
  - 32'h80000000 -> 0, flags 0
  - 32'h00000001 -> 0, inexact=1
- Exact large values:
  - 32'h4EFFFFFF -> 2147483520
  - 32'h4B000001 -> 8388609
  - both inexact=0.
- Truncate mode (ROUND_RNE=0): 32'h3F7FFFFF -> 0 and 32'hC0600000 -> 32'hFFFFFFFD.
- Backpressure:
  - Stream 8 back-to-back operands 1.0..8.0 while holding out_ready=0 from cycle 4 to cycle 9.
  - Required: in_ready=0 throughout the stall, out_int stable, and results 1..8 delivered in order with no loss or duplication.
- Reset mid-stream:
  - Assert rst for 1 cycle with 3 operands in flight.
  - Required: out_valid=0 the next cycle, no stale results ever emitted, and a new operand 32'h41200000 yields 10 with latency 3.
